// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer.
// Op codes match the universal shift register's mode-select encoding one-for-one.
package shift_ctrl_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NOP  = 2'b00;
    localparam op_t OP_SHR  = 2'b01;
    localparam op_t OP_SHL  = 2'b10;
    localparam op_t OP_LOAD = 2'b11;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_LOAD  = 2'b01;
    localparam state_t ST_SHIFT = 2'b10;
    localparam state_t ST_DONE  = 2'b11;

    function automatic logic is_shift_op(input op_t op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/shift_count_down.sv
// Loadable down-counter with a terminal flag raised while the count equals one.
module shift_count_down #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_register_sequencer.sv
// Command sequencer driving a universal shift register: one op per handshake,
// multi-bit shifts issued as repeated single shifts with q fed back on data_in.
//
// state    | meaning
// ST_IDLE  | ready for a command, register held
// ST_LOAD  | one-cycle parallel load of the latched data
// ST_SHIFT | one shift per cycle until the counter reaches its last step
// ST_DONE  | one-cycle done pulse, register holds the result
module shift_register_sequencer
    import shift_ctrl_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amount,
    input  logic             cmd_rotate,
    input  logic             cmd_fill,
    input  logic [SIZE-1:0]  cmd_data,
    input  logic [SIZE-1:0]  sr_q,
    output logic             sr_select_1,
    output logic             sr_select_0,
    output logic             sr_left_serial_in,
    output logic             sr_right_serial_in,
    output logic [SIZE-1:0]  sr_data_in,
    output logic             busy,
    output logic             done
);

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic            rotate_q, rotate_d;
    logic            fill_q, fill_d;
    logic [SIZE-1:0] data_q, data_d;

    logic accept;
    logic cnt_last;
    logic in_shift;
    op_t  select;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rotate_d = rotate_q;
        fill_d   = fill_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = cmd_op;
                    rotate_d = cmd_rotate;
                    fill_d   = cmd_fill;
                    data_d   = cmd_data;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (is_shift_op(cmd_op) && (cmd_amount != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD:  state_d = ST_DONE;
            ST_SHIFT: if (cnt_last) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            rotate_q <= 1'b0;
            fill_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rotate_q <= rotate_d;
            fill_q   <= fill_d;
            data_q   <= data_d;
        end
    end

    shift_count_down #(
        .CNT_W(CNT_W)
    ) u_count (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .load_val_i(cmd_amount),
        .dec_i     (state_q == ST_SHIFT),
        .last_o    (cnt_last)
    );

    // Reset gates every output so an aborted shift cannot clock the register once more.
    assign in_shift = (state_q == ST_SHIFT) && !reset;

    always_comb begin
        select = OP_NOP;
        if (!reset) begin
            if (state_q == ST_LOAD)       select = OP_LOAD;
            else if (state_q == ST_SHIFT) select = op_q;
        end
    end

    assign sr_select_1 = select[1];
    assign sr_select_0 = select[0];

    assign sr_data_in = (state_q == ST_LOAD) ? data_q : sr_q;

    assign sr_left_serial_in  = (in_shift && (op_q == OP_SHR)) ?
                                (rotate_q ? sr_q[0] : fill_q) : 1'b0;
    assign sr_right_serial_in = (in_shift && (op_q == OP_SHL)) ?
                                (rotate_q ? sr_q[SIZE-1] : fill_q) : 1'b0;

    assign cmd_ready = !reset && (state_q == ST_IDLE);
    assign busy      = !reset && (state_q != ST_IDLE);
    assign done      = !reset && (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed end-to-end bench: the sequencer drives a behavioural 4-bit universal
// shift register, and outputs are sampled 1 time unit after each rising edge.
module tb_shift_register_sequencer;

    localparam int SIZE  = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amount;
    logic             cmd_rotate;
    logic             cmd_fill;
    logic [SIZE-1:0]  cmd_data;
    logic [SIZE-1:0]  sr_q;
    logic             sr_select_1;
    logic             sr_select_0;
    logic             sr_left_serial_in;
    logic             sr_right_serial_in;
    logic [SIZE-1:0]  sr_data_in;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_register_sequencer #(
        .SIZE (SIZE),
        .CNT_W(CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_amount        (cmd_amount),
        .cmd_rotate        (cmd_rotate),
        .cmd_fill          (cmd_fill),
        .cmd_data          (cmd_data),
        .sr_q              (sr_q),
        .sr_select_1       (sr_select_1),
        .sr_select_0       (sr_select_0),
        .sr_left_serial_in (sr_left_serial_in),
        .sr_right_serial_in(sr_right_serial_in),
        .sr_data_in        (sr_data_in),
        .busy              (busy),
        .done              (done)
    );

    // Universal shift register: 00 hold, 01 right, 10 left, 11 load.
    always_ff @(posedge clk) begin
        case ({sr_select_1, sr_select_0})
            2'b01:   sr_q <= {sr_left_serial_in, sr_data_in[SIZE-1:1]};
            2'b10:   sr_q <= {sr_data_in[SIZE-2:0], sr_right_serial_in};
            2'b11:   sr_q <= sr_data_in;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [CNT_W-1:0] amt,
                         input logic rot, input logic fill, input logic [SIZE-1:0] data);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_amount = amt;
        cmd_rotate = rot;
        cmd_fill   = fill;
        cmd_data   = data;
    endtask

    // Accept a LOAD, then step through its LOAD and DONE cycles back to IDLE.
    task automatic do_load(input string tag, input logic [SIZE-1:0] data);
        drive(2'b11, 3'd0, 1'b0, 1'b0, data);
        chk({tag, "_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_sel"}, {sr_select_1, sr_select_0}, 2'b11);
        chk({tag, "_din"}, sr_data_in, data);
        chk({tag, "_nodone"}, done, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sel00"}, {sr_select_1, sr_select_0}, 2'b00);
        chk({tag, "_q"}, sr_q, data);
        tick();
        chk({tag, "_idle"}, cmd_ready, 1);
    endtask

    logic [SIZE-1:0] rot_q [7];

    initial begin
        rot_q = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_amount = '0;
        cmd_rotate = 1'b0;
        cmd_fill   = 1'b0;
        cmd_data   = '0;

        // Reset
        tick();
        tick();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel", {sr_select_1, sr_select_0}, 2'b00);
        chk("rst_ser", {sr_left_serial_in, sr_right_serial_in}, 2'b00);
        reset = 1'b0;
        #1;
        chk("rel_ready", cmd_ready, 1);

        // 1: LOAD 1011
        do_load("t1", 4'b1011);

        // 2: SHR 2 logical fill 0 from 1011
        drive(2'b01, 3'd2, 1'b0, 1'b0, 4'b0000);
        tick();
        cmd_valid = 1'b0;
        chk("t2_sel_a", {sr_select_1, sr_select_0}, 2'b01);
        chk("t2_din_a", sr_data_in, 4'b1011);
        chk("t2_busy", busy, 1);
        chk("t2_ready", cmd_ready, 0);
        tick();
        chk("t2_sel_b", {sr_select_1, sr_select_0}, 2'b01);
        chk("t2_q_mid", sr_q, 4'b0101);
        chk("t2_ser", {sr_left_serial_in, sr_right_serial_in}, 2'b00);
        tick();
        chk("t2_done", done, 1);
        chk("t2_q", sr_q, 4'b0010);
        chk("t2_sel00", {sr_select_1, sr_select_0}, 2'b00);
        tick();
        chk("t2_idle_done", done, 0);

        // 3: SHL 1 rotate from 1011
        do_load("t3l", 4'b1011);
        drive(2'b10, 3'd1, 1'b1, 1'b0, 4'b0000);
        tick();
        cmd_valid = 1'b0;
        chk("t3_sel", {sr_select_1, sr_select_0}, 2'b10);
        chk("t3_rsi", sr_right_serial_in, 1);
        chk("t3_lsi", sr_left_serial_in, 0);
        tick();
        chk("t3_done", done, 1);
        chk("t3_q", sr_q, 4'b0111);
        tick();

        // 4: SHR amount 0, then NOP
        drive(2'b01, 3'd0, 1'b0, 1'b1, 4'b0000);
        tick();
        cmd_valid = 1'b0;
        chk("t4a_done", done, 1);
        chk("t4a_sel", {sr_select_1, sr_select_0}, 2'b00);
        tick();
        chk("t4a_q", sr_q, 4'b0111);
        drive(2'b00, 3'd5, 1'b0, 1'b1, 4'b1111);
        tick();
        cmd_valid = 1'b0;
        chk("t4b_done", done, 1);
        chk("t4b_sel", {sr_select_1, sr_select_0}, 2'b00);
        tick();
        chk("t4b_q", sr_q, 4'b0111);
        chk("t4b_idle", cmd_ready, 1);

        // 5: SHR rotate 7 from 1000; valid held with a new command during busy
        do_load("t5l", 4'b1000);
        drive(2'b01, 3'd7, 1'b1, 1'b0, 4'b0000);
        tick();
        drive(2'b11, 3'd3, 1'b0, 1'b1, 4'b0110);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t5_sel%0d", i), {sr_select_1, sr_select_0}, 2'b01);
            chk($sformatf("t5_q%0d", i), sr_q, rot_q[i]);
            chk($sformatf("t5_lsi%0d", i), sr_left_serial_in, rot_q[i][0]);
            chk($sformatf("t5_rdy%0d", i), cmd_ready, 0);
            tick();
        end
        chk("t5_done", done, 1);
        chk("t5_q", sr_q, 4'b0001);
        chk("t5_done_rdy", cmd_ready, 0);
        tick();
        chk("t5_idle_rdy", cmd_ready, 1);
        chk("t5_idle_sel", {sr_select_1, sr_select_0}, 2'b00);
        tick();
        cmd_valid = 1'b0;
        chk("t5_next_sel", {sr_select_1, sr_select_0}, 2'b11);
        chk("t5_next_din", sr_data_in, 4'b0110);
        tick();
        chk("t5_next_done", done, 1);
        chk("t5_next_q", sr_q, 4'b0110);
        tick();

        // 6: reset in the 3rd cycle of SHR 7 logical fill 1 from 0110
        drive(2'b01, 3'd7, 1'b0, 1'b1, 4'b0000);
        tick();
        cmd_valid = 1'b0;
        chk("t6_lsi", sr_left_serial_in, 1);
        tick();
        chk("t6_q_mid", sr_q, 4'b1011);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_sel", {sr_select_1, sr_select_0}, 2'b00);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", cmd_ready, 0);
        chk("t6_rst_done", done, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_ready", cmd_ready, 1);
        chk("t6_q_kept", sr_q, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_nodone%0d", i), done, 0);
            chk($sformatf("t6_sel%0d", i), {sr_select_1, sr_select_0}, 2'b00);
            tick();
        end
        chk("t6_q_final", sr_q, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
